// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: load-extend and write-data select
// codes, reset constants, the MEM/WB register layout and the load extender.
package wb_stage_pkg;

   localparam int          NREG_DEF     = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

   typedef enum logic [2:0] {
      DM_LW  = 3'b000,
      DM_LB  = 3'b001,
      DM_LBU = 3'b010,
      DM_LH  = 3'b011,
      DM_LHU = 3'b100
   } dm_op_e;

   typedef enum logic [1:0] {
      WD_ALU = 2'b00,
      WD_MEM = 2'b01,
      WD_PC8 = 2'b10
   } wd_sel_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [4:0]  a3;
      logic [31:0] aluout;
      logic [31:0] dmrd;
      logic        change;
   } mw_reg_t;

   // Halfword select uses only offset[1]; misaligned halfwords never reach W.
   function automatic logic [31:0] load_extend(input logic [2:0]  mode,
                                               input logic [1:0]  offset,
                                               input logic [31:0] word);
      logic [7:0]  byte_sel;
      logic [15:0] half_sel;
      byte_sel = word[8*offset +: 8];
      half_sel = offset[1] ? word[31:16] : word[15:0];
      case (dm_op_e'(mode))
         DM_LB:   return {{24{byte_sel[7]}}, byte_sel};
         DM_LBU:  return {24'h0, byte_sel};
         DM_LH:   return {{16{half_sel[15]}}, half_sel};
         DM_LHU:  return {16'h0, half_sel};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/wb_stage_grf.sv
// 32x32 general purpose register file: one write port, two read ports that
// bypass the in-flight write so a same-cycle read sees the new value.
module wb_stage_grf
   import wb_stage_pkg::*;
#(
   parameter int NREG = NREG_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   logic [31:0] regs [NREG];

   // NOTE: the whole array is cleared by reset because the pipeline depends on
   // every GPR reading zero after reset; this costs a reset on each flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we && wa != 5'd0) begin
         // NOTE: non-blocking so every read in this cycle sees pre-edge state.
         regs[wa] <= wd;
      end
   end

   // NOTE: each output is assigned on every path, so no latch is inferred.
   always_comb begin
      if (ra1 == 5'd0)                rd1 = '0;
      else if (we && ra1 == wa)       rd1 = wd;
      else                            rd1 = regs[ra1];
      if (ra2 == 5'd0)                rd2 = '0;
      else if (we && ra2 == wa)       rd2 = wd;
      else                            rd2 = regs[ra2];
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load extension, write-data select
// and the GPR file, plus the W-stage forwarding sources.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int          NREG     = NREG_DEF,
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instrM,
   input  logic [31:0] pcM,
   input  logic [4:0]  a3M,
   input  logic [31:0] aluoutM,
   input  logic [31:0] dmrdM,
   input  logic        changeM,
   input  logic        flushM,
   input  logic        regwrite,
   input  logic [1:0]  wdctr,
   input  logic [2:0]  dmoctr,
   output logic [31:0] instrW,
   output logic        changeW,
   output logic [4:0]  a3W,
   output logic [31:0] wdW,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   mw_reg_t     w_q;
   logic [31:0] load_data;
   logic        we;

   // A flushed slot keeps its PC but carries no instruction and no destination.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_q <= '{instr: '0, pc: RESET_PC, a3: '0, aluout: '0, dmrd: '0, change: 1'b0};
      end else if (flushM) begin
         w_q <= '{instr: '0, pc: pcM, a3: '0, aluout: '0, dmrd: '0, change: 1'b0};
      end else begin
         w_q <= '{instr: instrM, pc: pcM, a3: a3M, aluout: aluoutM,
                  dmrd: dmrdM, change: changeM};
      end
   end

   assign load_data = load_extend(dmoctr, w_q.aluout[1:0], w_q.dmrd);

   always_comb begin
      case (wd_sel_e'(wdctr))
         WD_MEM:  wdW = load_data;
         WD_PC8:  wdW = w_q.pc + 32'd8;
         default: wdW = w_q.aluout;
      endcase
   end

   // Conditional link/move writes arrive already folded into regwrite.
   assign we      = regwrite && (w_q.a3 != 5'd0);
   assign a3W     = we ? w_q.a3 : 5'd0;
   assign instrW  = w_q.instr;
   assign changeW = w_q.change;

   wb_stage_grf #(
      .NREG (NREG)
   ) u_grf (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .wa    (w_q.a3),
      .wd    (wdW),
      .ra1   (ra1),
      .ra2   (ra2),
      .rd1   (rd1),
      .rd2   (rd2)
   );

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: expected W-stage results are queued when an
// instruction is driven into M and compared when it appears in W.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instrM, pcM, aluoutM, dmrdM;
   logic [4:0]  a3M;
   logic        changeM, flushM, regwrite;
   logic [1:0]  wdctr;
   logic [2:0]  dmoctr;
   logic [31:0] instrW, wdW, rd1, rd2;
   logic        changeW;
   logic [4:0]  a3W, ra1, ra2;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      logic [31:0] instr;
      logic [4:0]  a3;
      logic [31:0] wd;
      logic        change;
   } exp_t;

   exp_t sb[$];

   wb_stage dut (
      .clk      (clk),
      .reset    (reset),
      .instrM   (instrM),
      .pcM      (pcM),
      .a3M      (a3M),
      .aluoutM  (aluoutM),
      .dmrdM    (dmrdM),
      .changeM  (changeM),
      .flushM   (flushM),
      .regwrite (regwrite),
      .wdctr    (wdctr),
      .dmoctr   (dmoctr),
      .instrW   (instrW),
      .changeW  (changeW),
      .a3W      (a3W),
      .wdW      (wdW),
      .ra1      (ra1),
      .ra2      (ra2),
      .rd1      (rd1),
      .rd2      (rd2)
   );

   always #5 clk = ~clk;

   // Drive one instruction into M, let it cross into W, apply its decode and
   // compare the W-stage outputs against the queued expectation.
   task automatic step(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [4:0] a3, input logic [31:0] aluout,
                       input logic [31:0] dmrd, input logic change,
                       input logic flush, input logic rw,
                       input logic [1:0] wdc, input logic [2:0] dmo,
                       input logic [4:0] exp_a3, input logic [31:0] exp_wd,
                       input string name);
      exp_t e;
      instrM = instr; pcM = pc; a3M = a3; aluoutM = aluout; dmrdM = dmrd;
      changeM = change; flushM = flush;
      sb.push_back('{instr: flush ? 32'h0 : instr, a3: exp_a3, wd: exp_wd,
                     change: flush ? 1'b0 : change});
      @(posedge clk);
      #1;
      regwrite = rw; wdctr = wdc; dmoctr = dmo;
      #1;
      tests_run++;
      if (sb.size() == 0) begin
         tests_failed++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         if (instrW !== e.instr || a3W !== e.a3 || wdW !== e.wd || changeW !== e.change) begin
            tests_failed++;
            $display("FAIL %s: got instrW=%h a3W=%0d wdW=%h changeW=%b, want instrW=%h a3W=%0d wdW=%h changeW=%b",
                     name, instrW, a3W, wdW, changeW, e.instr, e.a3, e.wd, e.change);
         end
      end
   endtask

   task automatic nop();
      step(32'h0, 32'h0000_3ffc, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000,
           5'd0, 32'h0, "nop");
   endtask

   task automatic read_both(input logic [4:0] addr, input logic [31:0] exp, input string name);
      ra1 = addr; ra2 = addr;
      #1;
      tests_run++;
      if (rd1 !== exp || rd2 !== exp) begin
         tests_failed++;
         $display("FAIL %s: rd1=%h rd2=%h for $%0d, want %h", name, rd1, rd2, addr, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; regwrite = 1'b0; wdctr = 2'b10; dmoctr = 3'b000;
      instrM = '0; pcM = '0; a3M = '0; aluoutM = '0; dmrdM = '0;
      changeM = 1'b0; flushM = 1'b0; ra1 = 5'd0; ra2 = 5'd0;
      #2;
      tests_run++;
      if (instrW !== 32'h0 || changeW !== 1'b0 || a3W !== 5'd0 || wdW !== 32'h0000_3008) begin
         tests_failed++;
         $display("FAIL reset_state: instrW=%h changeW=%b a3W=%0d wdW=%h, want 0 0 0 00003008",
                  instrW, changeW, a3W, wdW);
      end
      read_both(5'd8, 32'h0, "reset_gpr8");
      read_both(5'd31, 32'h0, "reset_gpr31");
      @(negedge clk);
      reset = 1'b0;
      wdctr = 2'b00;
   endtask

   task automatic test_alu();
      step(32'h0109_4021, 32'h0000_3000, 5'd8, 32'h0000_1234, 32'h0, 1'b0, 1'b0,
           1'b1, 2'b00, 3'b000, 5'd8, 32'h0000_1234, "addu_w");
      read_both(5'd8, 32'h0000_1234, "addu_bypass");
      nop();
      read_both(5'd8, 32'h0000_1234, "addu_array");
   endtask

   task automatic test_loads();
      step(32'h8000_0002, 32'h3004, 5'd9,  32'h0000_1002, 32'h1180_2233, 1'b0, 1'b0,
           1'b1, 2'b01, 3'b001, 5'd9,  32'hFFFF_FF80, "lb_off2");
      step(32'h9000_0002, 32'h3008, 5'd10, 32'h0000_1002, 32'h1180_2233, 1'b0, 1'b0,
           1'b1, 2'b01, 3'b010, 5'd10, 32'h0000_0080, "lbu_off2");
      step(32'h8400_0002, 32'h300c, 5'd11, 32'h0000_1002, 32'h1180_2233, 1'b0, 1'b0,
           1'b1, 2'b01, 3'b011, 5'd11, 32'h0000_1180, "lh_hi");
      step(32'h9400_0002, 32'h3010, 5'd12, 32'h0000_1002, 32'h8000_0000, 1'b0, 1'b0,
           1'b1, 2'b01, 3'b100, 5'd12, 32'h0000_8000, "lhu_hi");
      step(32'h8c00_0000, 32'h3014, 5'd13, 32'h0000_1000, 32'hCAFE_BABE, 1'b0, 1'b0,
           1'b1, 2'b01, 3'b000, 5'd13, 32'hCAFE_BABE, "lw");
      step(32'h8000_0000, 32'h3018, 5'd20, 32'h0000_1000, 32'h1180_2233, 1'b0, 1'b0,
           1'b1, 2'b01, 3'b001, 5'd20, 32'h0000_0033, "lb_off0");
      step(32'h8000_0003, 32'h301c, 5'd21, 32'h0000_1003, 32'h1180_2233, 1'b0, 1'b0,
           1'b1, 2'b01, 3'b010, 5'd21, 32'h0000_0011, "lbu_off3");
      step(32'h8400_0003, 32'h3020, 5'd22, 32'h0000_1003, 32'h8000_0000, 1'b0, 1'b0,
           1'b1, 2'b01, 3'b011, 5'd22, 32'hFFFF_8000, "lh_odd_hi");
      step(32'h8400_0000, 32'h3024, 5'd23, 32'h0000_1000, 32'h0000_F00D, 1'b0, 1'b0,
           1'b1, 2'b01, 3'b011, 5'd23, 32'hFFFF_F00D, "lh_lo");
      nop();
      read_both(5'd9,  32'hFFFF_FF80, "lb_array");
      read_both(5'd12, 32'h0000_8000, "lhu_array");
   endtask

   task automatic test_jal();
      step(32'h0C00_0C00, 32'h0000_3010, 5'd31, 32'h0, 32'h0, 1'b0, 1'b0,
           1'b1, 2'b10, 3'b000, 5'd31, 32'h0000_3018, "jal_w");
      nop();
      read_both(5'd31, 32'h0000_3018, "jal_array");
   endtask

   task automatic test_zero_reg();
      step(32'h0000_0021, 32'h0000_3030, 5'd0, 32'h0000_DEAD, 32'h0, 1'b0, 1'b0,
           1'b1, 2'b00, 3'b000, 5'd0, 32'h0000_DEAD, "write_r0");
      read_both(5'd0, 32'h0, "r0_same_cycle");
      nop();
      read_both(5'd0, 32'h0, "r0_next_cycle");
   endtask

   task automatic test_cond_and_flush();
      step(32'h0411_0004, 32'h0000_3100, 5'd31, 32'h0, 32'h0, 1'b1, 1'b0,
           1'b0, 2'b10, 3'b000, 5'd0, 32'h0000_3108, "bgezal_suppressed");
      nop();
      read_both(5'd31, 32'h0000_3018, "bgezal_r31_kept");
      step(32'h8C0D_0000, 32'h0000_3104, 5'd13, 32'h0000_0055, 32'h0, 1'b1, 1'b1,
           1'b1, 2'b00, 3'b000, 5'd0, 32'h0, "flush_bubble");
      nop();
      read_both(5'd13, 32'hCAFE_BABE, "flush_r13_kept");
   endtask

   task automatic test_back_to_back();
      step(32'h0000_7021, 32'h3200, 5'd14, 32'h0000_000A, 32'h0, 1'b0, 1'b0,
           1'b1, 2'b00, 3'b000, 5'd14, 32'h0000_000A, "b2b_first");
      step(32'h0000_7021, 32'h3204, 5'd14, 32'h0000_000B, 32'h0, 1'b0, 1'b0,
           1'b1, 2'b00, 3'b000, 5'd14, 32'h0000_000B, "b2b_second");
      read_both(5'd14, 32'h0000_000B, "b2b_newest_bypass");
      step(32'h0000_7821, 32'h3208, 5'd15, 32'h0000_00F0, 32'h0, 1'b0, 1'b0,
           1'b1, 2'b00, 3'b000, 5'd15, 32'h0000_00F0, "b2b_r15");
      read_both(5'd14, 32'h0000_000B, "b2b_r14_array");
      nop();
      read_both(5'd15, 32'h0000_00F0, "b2b_r15_array");
   endtask

   task automatic test_async_reset();
      step(32'h0000_2821, 32'h3300, 5'd5, 32'h0000_0007, 32'h0, 1'b0, 1'b0,
           1'b1, 2'b00, 3'b000, 5'd5, 32'h0000_0007, "load_r5");
      step(32'h1234_5678, 32'h3304, 5'd6, 32'h0000_0066, 32'h0, 1'b0, 1'b0,
           1'b1, 2'b00, 3'b000, 5'd6, 32'h0000_0066, "pending_r6");
      read_both(5'd5, 32'h0000_0007, "r5_before_reset");
      reset = 1'b1;
      #1;
      tests_run++;
      if (instrW !== 32'h0 || a3W !== 5'd0) begin
         tests_failed++;
         $display("FAIL async_reset_w: instrW=%h a3W=%0d, want 0 0", instrW, a3W);
      end
      read_both(5'd5, 32'h0, "async_reset_r5");
      @(negedge clk);
      reset = 1'b0; regwrite = 1'b0;
      instrM = '0; a3M = '0;
      @(posedge clk);
      #2;
      read_both(5'd6, 32'h0, "pending_write_lost");
   endtask

   initial begin
      test_reset();
      test_alu();
      test_loads();
      test_jal();
      test_zero_reg();
      test_cond_and_flush();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
